dpram_fifo_ctrl: RTL

First-word-fall-through FIFO controller that sits directly in front of `dpram` and owns both of its ports. Port A is the write port and port B the read port. It converts valid/ready streams on both sides into `dpram` address/wren/data traffic. A 2-entry output stage hides the RAM's 1-cycle registered read latency, so the controller sustains one push and one pop per cycle.

---
 rtl/dpram_fifo_ctrl_if.sv | 35 +++
 rtl/dpram_fifo_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/dpram_fifo_ctrl_if.sv
// Stream and RAM-port bundle for dpram_fifo_ctrl.
// master = the controller that owns both RAM ports; slave = the user and RAM side.
interface dpram_fifo_ctrl_if #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32
);
  logic [DWIDTH-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [AWIDTH+1:0] count;
  logic [AWIDTH-1:0] ram_address_a;
  logic              ram_wren_a;
  logic [DWIDTH-1:0] ram_data_a;
  logic [AWIDTH-1:0] ram_address_b;
  logic              ram_wren_b;
  logic [DWIDTH-1:0] ram_data_b;
  logic [DWIDTH-1:0] ram_out_b;

  modport master (
    input  in_data, in_valid, out_ready, ram_out_b,
    output in_ready, out_data, out_valid, count,
           ram_address_a, ram_wren_a, ram_data_a,
           ram_address_b, ram_wren_b, ram_data_b
  );

  modport slave (
    output in_data, in_valid, out_ready, ram_out_b,
    input  in_ready, out_data, out_valid, count,
           ram_address_a, ram_wren_a, ram_data_a,
           ram_address_b, ram_wren_b, ram_data_b
  );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving a dual-port RAM (A = write, B = read).
// A 2-entry output stage absorbs the RAM's registered read so push and pop both run at full rate.
module dpram_fifo_ctrl #(
  parameter int AWIDTH    = 10,
  parameter int NUM_WORDS = 1024,
  parameter int DWIDTH    = 32
) (
  input  logic               clk,
  input  logic               reset,
  dpram_fifo_ctrl_if.master  bus
);

  localparam int PW = AWIDTH + 1;
  localparam int CW = AWIDTH + 2;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     ram_count;
  logic              inflight_q, inflight_d;
  state_t            state_q, state_d;
  logic [DWIDTH-1:0] ent0_q, ent0_d;
  logic [DWIDTH-1:0] ent1_q, ent1_d;
  logic              in_ready;
  logic              out_valid;
  logic              push;
  logic              pop;
  logic              rd_issue;
  logic [1:0]        stage_cnt;
  logic [2:0]        occ_after_pop;

  // Pointer arithmetic and read-issue decision
  always_comb begin
    ram_count     = wr_ptr_q - rd_ptr_q;
    in_ready      = (ram_count != PW'(NUM_WORDS)) & ~reset;
    push          = bus.in_valid & in_ready;
    pop           = out_valid & bus.out_ready;
    occ_after_pop = 3'(stage_cnt) + 3'(inflight_q) - 3'(pop);
    // Only issue when the stage is guaranteed a free slot when the word lands.
    rd_issue      = (ram_count != '0) && (occ_after_pop < 3'd2);
    wr_ptr_d      = wr_ptr_q + PW'(push);
    rd_ptr_d      = rd_ptr_q + PW'(rd_issue);
    inflight_d    = rd_issue;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      state_q    <= EMPTY;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      state_q    <= state_d;
    end
  end

  // Output stage FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (inflight_q) state_d = ONE;
      ONE: begin
        if (pop && !inflight_q)      state_d = EMPTY;
        else if (inflight_q && !pop) state_d = TWO;
      end
      TWO:     if (pop && !inflight_q) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Output stage FSM: outputs
  always_comb begin
    out_valid = (state_q != EMPTY);
    unique case (state_q)
      ONE:     stage_cnt = 2'd1;
      TWO:     stage_cnt = 2'd2;
      default: stage_cnt = 2'd0;
    endcase
  end

  // Stage data: apply the pop first, then land the returning word in the first free slot
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    unique case (state_q)
      EMPTY: if (inflight_q) ent0_d = bus.ram_out_b;
      ONE: begin
        if (inflight_q) begin
          if (pop) ent0_d = bus.ram_out_b;
          else     ent1_d = bus.ram_out_b;
        end
      end
      TWO: begin
        if (pop) begin
          ent0_d = ent1_q;
          if (inflight_q) ent1_d = bus.ram_out_b;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ent0_q <= '0;
    else       ent0_q <= ent0_d;
  end

  // Skid entry is only ever read while state_q says it holds a word, so it needs no reset.
  always_ff @(posedge clk) begin
    ent1_q <= ent1_d;
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid;
  assign bus.out_data      = ent0_q;
  assign bus.count         = CW'(ram_count) + CW'(inflight_q) + CW'(stage_cnt);
  assign bus.ram_address_a = wr_ptr_q[AWIDTH-1:0];
  assign bus.ram_wren_a    = push;
  assign bus.ram_data_a    = bus.in_data;
  assign bus.ram_address_b = rd_ptr_q[AWIDTH-1:0];
  assign bus.ram_wren_b    = 1'b0;
  assign bus.ram_data_b    = '0;

  a_no_stage_overflow: assert property (
    @(posedge clk) disable iff (reset) !(state_q == TWO && inflight_q && !pop)
  );

endmodule
